// File: rtl/uart_pkg.sv
// Shared types for the UART transmit queue: drain FSM states and the byte type.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    SETTLE,
    WAIT
  } state_t;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/dual_push_fifo.sv
// Two-writer, one-reader byte FIFO; a push is written on the clock edge that samples it, and a pop frees space on the following cycle.
// Each source has its own ready. Source 1 needs two free slots, so a dual push always fits; a push while not ready is dropped and sets a sticky flag.
module dual_push_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           i_push0,
  input  byte_t          i_data0,
  input  logic           i_push1,
  input  byte_t          i_data1,
  input  logic           i_pop,
  output logic           o_ready0,
  output logic           o_ready1,
  output byte_t          o_rd_data,
  output logic [PTR_W:0] o_count,
  output logic           o_overflow
);

  localparam int CNT_W = PTR_W + 1;

  byte_t            r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_overflow;
  logic             w_acc0;
  logic             w_acc1;
  logic             w_drop;

  assign o_ready0   = (r_count <= CNT_W'(DEPTH - 1));
  assign o_ready1   = (r_count <= CNT_W'(DEPTH - 2));
  assign w_acc0     = i_push0 & o_ready0;
  assign w_acc1     = i_push1 & o_ready1;
  assign w_drop     = (i_push0 & ~o_ready0) | (i_push1 & ~o_ready1);
  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

  // Source 0 always lands first; source 1 slides up one slot when both fire.
  always_ff @(posedge clock) begin
    if (w_acc0) r_mem[r_wr_ptr] <= i_data0;
    if (w_acc1) r_mem[r_wr_ptr + PTR_W'(w_acc0)] <= i_data1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + PTR_W'(w_acc0) + PTR_W'(w_acc1);
      r_rd_ptr   <= r_rd_ptr + PTR_W'(i_pop);
      r_count    <= r_count + CNT_W'(w_acc0) + CNT_W'(w_acc1) - CNT_W'(i_pop);
      r_overflow <= r_overflow | w_drop;
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Merges two byte producers into one ordered queue and drains it into UartTx; push-to-tx_start is 2 cycles minimum.
// Per-source ready from the FIFO; draining waits for tx_busy low, with one settle cycle after each start.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           push0,
  input  logic [7:0]     data0,
  input  logic           push1,
  input  logic [7:0]     data1,
  output logic           ready0,
  output logic           ready1,
  output logic           tx_start,
  output logic [7:0]     sdata,
  input  logic           tx_busy,
  output logic [PTR_W:0] count,
  output logic           overflow
);

  state_t         r_state;
  byte_t          r_sdata;
  logic           r_tx_start;
  logic           w_pop;
  byte_t          w_rd_data;
  logic [PTR_W:0] w_count;

  dual_push_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .i_push0    (push0),
    .i_data0    (data0),
    .i_push1    (push1),
    .i_data1    (data1),
    .i_pop      (w_pop),
    .o_ready0   (ready0),
    .o_ready1   (ready1),
    .o_rd_data  (w_rd_data),
    .o_count    (w_count),
    .o_overflow (overflow)
  );

  assign w_pop    = (r_state == IDLE) && (w_count != '0) && !tx_busy;
  assign tx_start = r_tx_start;
  assign sdata    = r_sdata;
  assign count    = w_count;

  // SETTLE ignores tx_busy because the transmitter raises it one cycle after the start pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_sdata    <= 8'h00;
      r_tx_start <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_sdata    <= w_rd_data;
            r_tx_start <= 1'b1;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          r_tx_start <= 1'b0;
          r_state    <= SETTLE;
        end
        SETTLE: r_state <= WAIT;
        WAIT: begin
          if (!tx_busy) r_state <= IDLE;
        end
        default: begin
          r_tx_start <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a UartTx busy model that rises one cycle after each start pulse.
module tb_uart_tx_queue;

  localparam int BLEN = 6;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       push0 = 1'b0;
  logic [7:0] data0 = 8'h00;
  logic       push1 = 1'b0;
  logic [7:0] data1 = 8'h00;
  logic       ready0;
  logic       ready1;
  logic       tx_start;
  logic [7:0] sdata;
  logic       tx_busy = 1'b0;
  logic [4:0] count;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  int cyc        = 0;
  int busy_cnt   = 0;
  bit start_pend = 1'b0;
  bit busy_hold  = 1'b0;
  int last_busy  = -100;
  int overlap    = 0;

  logic [7:0] sent[$];
  int         scyc[$];
  int         sgap[$];

  uart_tx_queue #(.DEPTH(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .push0    (push0),
    .data0    (data0),
    .push1    (push1),
    .data1    (data1),
    .ready0   (ready0),
    .ready1   (ready1),
    .tx_start (tx_start),
    .sdata    (sdata),
    .tx_busy  (tx_busy),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  // Monitor and busy model, evaluated 1 time unit after every rising edge.
  always @(posedge clock) begin
    #1;
    cyc = cyc + 1;
    if (tx_start === 1'b1) begin
      sent.push_back(sdata);
      scyc.push_back(cyc);
      sgap.push_back(cyc - last_busy);
    end
    if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    if (start_pend) begin
      busy_cnt   = BLEN;
      start_pend = 1'b0;
    end
    if (tx_start === 1'b1) start_pend = 1'b1;
    tx_busy = busy_hold || (busy_cnt > 0);
    if (tx_busy) last_busy = cyc;
    if (tx_start === 1'b1 && tx_busy) overlap = overlap + 1;
  end

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clock);
    #2;
  endtask

  task automatic clear_log();
    sent.delete();
    scyc.delete();
    sgap.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(1);
    total++; if (count !== 5'd0)     begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (tx_start !== 1'b0)  begin bad++; $display("FAIL reset_tx_start got=%b want=0", tx_start); end
    total++; if (sdata !== 8'h00)    begin bad++; $display("FAIL reset_sdata got=%h want=00", sdata); end
    total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    total++; if ({ready0, ready1} !== 2'b11) begin bad++; $display("FAIL reset_ready got=%b%b want=11", ready0, ready1); end
  endtask

  task automatic test_single();
    int p;
    clear_log();
    @(posedge clock); #2;
    p = cyc; push0 = 1'b1; data0 = 8'hA5;
    @(posedge clock); #2;
    push0 = 1'b0;
    wait_cycles(20);
    total++; if (sent.size() !== 1) begin bad++; $display("FAIL single_starts got=%0d want=1", sent.size()); end
    if (sent.size() >= 1) begin
      total++; if (sent[0] !== 8'hA5) begin bad++; $display("FAIL single_sdata got=%h want=a5", sent[0]); end
      total++; if (scyc[0] - p !== 2) begin bad++; $display("FAIL single_latency got=%0d want=2", scyc[0] - p); end
    end
    total++; if (count !== 5'd0)    begin bad++; $display("FAIL single_count got=%0d want=0", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL single_overflow got=%b want=0", overflow); end
  endtask

  task automatic test_simultaneous();
    clear_log();
    overlap = 0;
    @(posedge clock); #2;
    push0 = 1'b1; data0 = 8'h11;
    push1 = 1'b1; data1 = 8'h22;
    @(posedge clock); #2;
    push0 = 1'b0; push1 = 1'b0;
    total++; if (count !== 5'd2) begin bad++; $display("FAIL simul_count got=%0d want=2", count); end
    wait_cycles(40);
    total++; if (sent.size() !== 2) begin bad++; $display("FAIL simul_starts got=%0d want=2", sent.size()); end
    if (sent.size() == 2) begin
      total++; if (sent[0] !== 8'h11) begin bad++; $display("FAIL simul_first got=%h want=11", sent[0]); end
      total++; if (sent[1] !== 8'h22) begin bad++; $display("FAIL simul_second got=%h want=22", sent[1]); end
      total++; if (sgap[1] < 3) begin bad++; $display("FAIL simul_gap got=%0d want>=3", sgap[1]); end
    end
    total++; if (overlap !== 0) begin bad++; $display("FAIL simul_overlap got=%0d want=0", overlap); end
  endtask

  task automatic test_fill();
    clear_log();
    busy_hold = 1'b1;
    wait_cycles(2);
    for (int i = 0; i < 17; i++) begin
      @(posedge clock); #2;
      push0 = 1'b1; data0 = 8'h30 + 8'(i);
      @(posedge clock); #2;
      push0 = 1'b0;
      if (i == 14) begin
        total++; if (count !== 5'd15) begin bad++; $display("FAIL fill15_count got=%0d want=15", count); end
        total++; if ({ready0, ready1} !== 2'b10) begin bad++; $display("FAIL fill15_ready got=%b%b want=10", ready0, ready1); end
      end
      if (i == 15) begin
        total++; if (count !== 5'd16) begin bad++; $display("FAIL fill16_count got=%0d want=16", count); end
        total++; if ({ready0, ready1} !== 2'b00) begin bad++; $display("FAIL fill16_ready got=%b%b want=00", ready0, ready1); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill16_overflow got=%b want=0", overflow); end
      end
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fill17_overflow got=%b want=1", overflow); end
    total++; if (count !== 5'd16)   begin bad++; $display("FAIL fill17_count got=%0d want=16", count); end
    total++; if (sent.size() !== 0) begin bad++; $display("FAIL fill_held_starts got=%0d want=0", sent.size()); end
    busy_hold = 1'b0;
    wait_cycles(220);
    total++; if (sent.size() !== 16) begin bad++; $display("FAIL drain_starts got=%0d want=16", sent.size()); end
    for (int i = 0; i < 16 && i < sent.size(); i++) begin
      total++;
      if (sent[i] !== 8'h30 + 8'(i)) begin
        bad++; $display("FAIL drain_order idx=%0d got=%h want=%h", i, sent[i], 8'h30 + 8'(i));
      end
    end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL drain_count got=%0d want=0", count); end
  endtask

  task automatic test_push_during_drain();
    clear_log();
    overlap = 0;
    @(posedge clock); #2;
    push0 = 1'b1; data0 = 8'h40;
    @(posedge clock); #2;
    push0 = 1'b0;
    wait_cycles(3);
    push1 = 1'b1; data1 = 8'h7E;
    @(posedge clock); #2;
    push1 = 1'b0;
    total++; if (count !== 5'd1) begin bad++; $display("FAIL pdd_count got=%0d want=1", count); end
    wait_cycles(40);
    total++; if (sent.size() !== 2) begin bad++; $display("FAIL pdd_starts got=%0d want=2", sent.size()); end
    if (sent.size() == 2) begin
      total++; if (sent[0] !== 8'h40) begin bad++; $display("FAIL pdd_first got=%h want=40", sent[0]); end
      total++; if (sent[1] !== 8'h7E) begin bad++; $display("FAIL pdd_second got=%h want=7e", sent[1]); end
      total++; if (sgap[1] < 3) begin bad++; $display("FAIL pdd_gap got=%0d want>=3", sgap[1]); end
    end
    total++; if (overlap !== 0) begin bad++; $display("FAIL pdd_overlap got=%0d want=0", overlap); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #2;
      push0 = 1'b1; data0 = 8'h50 + 8'(i);
    end
    @(posedge clock); #2;
    push0 = 1'b0;
    wait_cycles(3);
    total++; if (count !== 5'd4) begin bad++; $display("FAIL mid_pre_count got=%0d want=4", count); end
    reset = 1'b1;
    @(posedge clock); #2;
    reset = 1'b0;
    clear_log();
    total++; if (count !== 5'd0)    begin bad++; $display("FAIL mid_count got=%0d want=0", count); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL mid_tx_start got=%b want=0", tx_start); end
    total++; if (sdata !== 8'h00)   begin bad++; $display("FAIL mid_sdata got=%h want=00", sdata); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid_overflow got=%b want=0", overflow); end
    wait_cycles(40);
    total++; if (sent.size() !== 0) begin bad++; $display("FAIL mid_no_start got=%0d want=0", sent.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fill();
    test_push_during_drain();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
